// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth helper, per-buffer default thresholds,
// FSM status bit order and umbrales_I slice layout.
package fifo_pkg;

    typedef enum logic [2:0] {
        BUF_MF  = 3'd0,
        BUF_VC0 = 3'd1,
        BUF_VC1 = 3'd2,
        BUF_D0  = 3'd3,
        BUF_D1  = 3'd4
    } buf_id_e;

    localparam int NUM_BUFS = 5;

    localparam int MF_AW = 2;
    localparam int VC_AW = 4;
    localparam int D_AW  = 2;

    localparam int MF_AE_DEFAULT = 1;
    localparam int MF_AF_DEFAULT = 3;
    localparam int VC_AE_DEFAULT = 4;
    localparam int VC_AF_DEFAULT = 12;
    localparam int D_AE_DEFAULT  = 1;
    localparam int D_AF_DEFAULT  = 3;

    // umbrales_I packs {af, ae} per buffer, MF in the lowest bits
    localparam int UMB_OFS_MF  = 0;
    localparam int UMB_OFS_VC0 = UMB_OFS_MF  + 2 * MF_AW;
    localparam int UMB_OFS_VC1 = UMB_OFS_VC0 + 2 * VC_AW;
    localparam int UMB_OFS_D0  = UMB_OFS_VC1 + 2 * VC_AW;
    localparam int UMB_OFS_D1  = UMB_OFS_D0  + 2 * D_AW;
    localparam int UMB_WIDTH   = UMB_OFS_D1  + 2 * D_AW;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // FIFO_error/FIFO_empty vectors are ordered {MF,VC0,VC1,D0,D1}, MF at the MSB
    function automatic int status_bit(input buf_id_e b);
        return NUM_BUFS - 1 - int'(b);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DW storage: synchronous write, registered read with enable.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Buffering FIFO with programmable almost-empty/almost-full thresholds,
// upstream pause and sticky overflow error.
module fifo_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int AE_DEFAULT = 1,
    parameter int AF_DEFAULT = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH-1:0] umbral_ae,
    input  logic [ADDR_WIDTH-1:0] umbral_af,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  pause,
    output logic                  fifo_error
);

    localparam int                DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] ae_reg, af_reg;
    logic                  wr_acc, rd_acc, overflow;

    // a full FIFO still accepts a write when a read frees a slot the same cycle
    assign wr_acc   = wr_en & (~fifo_full | rd_en);
    assign rd_acc   = rd_en & ~fifo_empty;
    assign overflow = wr_en & fifo_full & ~rd_en;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc & reset),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_acc & reset),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            fifo_error <= 1'b0;
            ae_reg     <= ADDR_WIDTH'(AE_DEFAULT);
            af_reg     <= ADDR_WIDTH'(AF_DEFAULT);
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            data_valid <= rd_acc;

            // init clears the error even when an overflow lands the same cycle
            if (init) begin
                ae_reg     <= umbral_ae;
                af_reg     <= umbral_af;
                fifo_error <= 1'b0;
            end else if (overflow) begin
                fifo_error <= 1'b1;
            end
        end
    end

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == DEPTH_C);
    assign almost_empty = (count <= {1'b0, ae_reg});
    assign almost_full  = (af_reg != '0) && (count >= {1'b0, af_reg});
    assign pause        = almost_full | fifo_full;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed + random bench for fifo_flow_ctrl: an AW=2 (MF-style) and an AW=4
// (VC-style) instance checked every cycle against queue-based reference models.
module tb_fifo_flow_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // instance a: AW=2, defaults AE=1 AF=3
    logic       a_init, a_we, a_re;
    logic [1:0] a_ae, a_af;
    logic [5:0] a_di, a_do;
    logic [2:0] a_cnt;
    logic       a_dv, a_emp, a_full, a_aemp, a_afull, a_pause, a_err;

    // instance b: AW=4, defaults AE=4 AF=12
    logic       b_init, b_we, b_re;
    logic [3:0] b_ae, b_af;
    logic [5:0] b_di, b_do;
    logic [4:0] b_cnt;
    logic       b_dv, b_emp, b_full, b_aemp, b_afull, b_pause, b_err;

    fifo_flow_ctrl #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .AE_DEFAULT(1), .AF_DEFAULT(3)) dut_a (
        .clk(clk), .reset(reset), .init(a_init), .umbral_ae(a_ae), .umbral_af(a_af),
        .wr_en(a_we), .data_in(a_di), .rd_en(a_re), .data_out(a_do), .data_valid(a_dv),
        .count(a_cnt), .fifo_empty(a_emp), .fifo_full(a_full), .almost_empty(a_aemp),
        .almost_full(a_afull), .pause(a_pause), .fifo_error(a_err)
    );

    fifo_flow_ctrl #(.DATA_WIDTH(6), .ADDR_WIDTH(4), .AE_DEFAULT(4), .AF_DEFAULT(12)) dut_b (
        .clk(clk), .reset(reset), .init(b_init), .umbral_ae(b_ae), .umbral_af(b_af),
        .wr_en(b_we), .data_in(b_di), .rd_en(b_re), .data_out(b_do), .data_valid(b_dv),
        .count(b_cnt), .fifo_empty(b_emp), .fifo_full(b_full), .almost_empty(b_aemp),
        .almost_full(b_afull), .pause(b_pause), .fifo_error(b_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    // reference model state: contents as a queue, plus registered outputs
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int         m_ae[2], m_af[2];
    bit         m_err[2], m_dv[2];
    logic [5:0] m_do[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model(input int k);
        bit ini, we, re, wok, rok;
        logic [5:0] di;
        int uae, uaf, depth, n;
        if (k == 0) begin
            ini = a_init; we = a_we; re = a_re; di = a_di; uae = a_ae; uaf = a_af;
            depth = 4; n = q0.size();
        end else begin
            ini = b_init; we = b_we; re = b_re; di = b_di; uae = b_ae; uaf = b_af;
            depth = 16; n = q1.size();
        end
        if (!reset) begin
            if (k == 0) q0.delete(); else q1.delete();
            m_dv[k] = 0; m_do[k] = '0; m_err[k] = 0;
            m_ae[k] = (k == 0) ? 1 : 4;
            m_af[k] = (k == 0) ? 3 : 12;
        end else begin
            wok = we && (n < depth || re);
            rok = re && n > 0;
            m_dv[k] = rok;
            if (rok) begin
                if (k == 0) m_do[k] = q0.pop_front(); else m_do[k] = q1.pop_front();
            end
            if (wok) begin
                if (k == 0) q0.push_back(di); else q1.push_back(di);
            end
            if (ini) begin
                m_err[k] = 0; m_ae[k] = uae; m_af[k] = uaf;
            end else if (we && n == depth && !re) begin
                m_err[k] = 1;
            end
        end
    endtask

    task automatic check_dut(input string p, input int k, input int n, input int depth,
                             input logic [31:0] cnt, input logic [31:0] emp, input logic [31:0] full,
                             input logic [31:0] aemp, input logic [31:0] afull, input logic [31:0] pse,
                             input logic [31:0] err, input logic [31:0] dv, input logic [31:0] dout);
        bit exp_af;
        exp_af = (m_af[k] != 0) && (n >= m_af[k]);
        chk({p, ".count"},        cnt,   n);
        chk({p, ".fifo_empty"},   emp,   32'(n == 0));
        chk({p, ".fifo_full"},    full,  32'(n == depth));
        chk({p, ".almost_empty"}, aemp,  32'(n <= m_ae[k]));
        chk({p, ".almost_full"},  afull, 32'(exp_af));
        chk({p, ".pause"},        pse,   32'(exp_af || n == depth));
        chk({p, ".fifo_error"},   err,   32'(m_err[k]));
        chk({p, ".data_valid"},   dv,    32'(m_dv[k]));
        chk({p, ".data_out"},     dout,  32'(m_do[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        model(0);
        model(1);
        #1;
        check_dut("a", 0, q0.size(), 4,  a_cnt, a_emp, a_full, a_aemp, a_afull, a_pause, a_err, a_dv, a_do);
        check_dut("b", 1, q1.size(), 16, b_cnt, b_emp, b_full, b_aemp, b_afull, b_pause, b_err, b_dv, b_do);
    endtask

    task automatic idle();
        a_init = 0; a_we = 0; a_re = 0;
        b_init = 0; b_we = 0; b_re = 0;
    endtask

    initial begin
        reset = 0; idle();
        a_ae = 0; a_af = 0; a_di = 0; b_ae = 0; b_af = 0; b_di = 0;
        tick(); tick();
        reset = 1;
        tick();

        // fill a to full with A..D, then overflow
        for (int i = 0; i < 4; i++) begin
            a_we = 1; a_di = 6'h0A + 6'(i); tick();
        end
        a_di = 6'h3F; tick();
        idle();
        for (int i = 0; i < 10; i++) tick();

        // drain in order, then a read on empty
        for (int i = 0; i < 5; i++) begin
            a_re = 1; tick();
        end
        idle();
        a_init = 1; a_ae = 1; a_af = 3; tick();
        idle();

        // wrap-around with interleaved write/read pairs
        for (int i = 0; i < 6; i++) begin
            a_we = 1; a_di = 6'($urandom); tick();
            a_we = 0; a_re = 1; tick();
            a_re = 0;
        end

        // simultaneous read+write on full and on empty
        for (int i = 0; i < 4; i++) begin
            a_we = 1; a_di = 6'h20 + 6'(i); tick();
        end
        a_re = 1; a_di = 6'h15; tick();
        a_we = 0;
        for (int i = 0; i < 4; i++) tick();
        a_we = 1; a_re = 1; a_di = 6'h2A; tick();
        idle();

        // thresholds on the AW=4 instance
        b_init = 1; b_ae = 4; b_af = 12; tick();
        b_init = 0;
        for (int i = 0; i < 12; i++) begin
            b_we = 1; b_di = 6'h30 + 6'(i); tick();
        end
        b_we = 0;
        b_init = 1; b_ae = 4; b_af = 0; tick();
        idle();

        // overflow, init clears it with contents kept (a currently holds 1 word)
        for (int i = 0; i < 4; i++) begin
            a_we = 1; a_di = 6'h01 + 6'(i); tick();
        end
        a_init = 1; a_ae = 2; a_af = 2; tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        a_we = 1; a_init = 1; a_di = 6'h33; tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            a_re = 1; tick();
        end

        // mid-stream reset with operations in flight
        a_re = 1; a_we = 1; b_re = 1; b_we = 1; reset = 0; tick();
        reset = 1; idle();
        for (int i = 0; i < 3; i++) begin
            a_we = 1; a_di = 6'(i); tick();
        end
        idle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 63) != 0);
            a_we   = 1'($urandom_range(0, 1)); a_re = 1'($urandom_range(0, 1));
            a_di   = 6'($urandom); a_init = ($urandom_range(0, 15) == 0);
            a_ae   = 2'($urandom); a_af = 2'($urandom);
            b_we   = ($urandom_range(0, 2) != 0); b_re = 1'($urandom_range(0, 1));
            b_di   = 6'($urandom); b_init = ($urandom_range(0, 15) == 0);
            b_ae   = 4'($urandom); b_af = 4'($urandom);
            tick();
        end
        reset = 1; idle(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
